smbus_mailbox_fifo_v2: RTL and testbench

Parametrised successor FIFO for the SMBus mailbox. It adds fill-level reporting, an almost-full threshold, sticky error flags, a selectable peek mode and a defined enqueue/dequeue collision rule. Storage is a single-port RAM with 1-cycle registered read. The block sits between the SMBus register decoder (enqueue/dequeue strobes) and mailbox data registers.

---
 rtl/smbus_mailbox_pkg.sv | 17 +
 rtl/smbus_mailbox_fifo_v2_if.sv | 35 +++
 rtl/sp_ram.sv | 20 ++
 rtl/smbus_mailbox_fifo_v2.sv | 109 ++++++++++
 tb/tb_smbus_mailbox_fifo_v2.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/smbus_mailbox_pkg.sv
// Shared types and pointer arithmetic for the SMBus mailbox FIFO.
// Pointers wrap at an arbitrary depth, so no power-of-two assumption anywhere.
package smbus_mailbox_pkg;

  typedef enum logic {
    PEEK_LAST = 1'b0,
    PEEK_HEAD = 1'b1
  } peek_mode_e;

  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned depth,
                                           input logic        dec);
    if (dec) return (ptr == 0) ? depth - 1 : ptr - 1;
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/smbus_mailbox_fifo_v2_if.sv
// Register-decoder side bus of the mailbox FIFO: strobes in, data and status out.
// The master modport is the decoder, the slave modport is the FIFO.
interface smbus_mailbox_fifo_v2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1023
);
  localparam int CW = $clog2(DATA_DEPTH + 1);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  enqueue;
  logic                  dequeue;
  logic                  clear;
  logic                  flag_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;
  logic                  collision;

  modport master (
    output data_in, enqueue, dequeue, clear, flag_clr,
    input  data_out, rd_valid, count, empty, full, almost_full,
           overflow, underflow, collision
  );

  modport slave (
    input  data_in, enqueue, dequeue, clear, flag_clr,
    output data_out, rd_valid, count, empty, full, almost_full,
           overflow, underflow, collision
  );
endinterface

// File: rtl/sp_ram.sv
// Single-port RAM with registered read; 1-cycle read latency, no backpressure.
// A read at the written address returns the old word.
module sp_ram #(
  parameter int NUMWORDS      = 1023,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     wren,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic [DATA_WIDTH-1:0]    q
);
  logic [DATA_WIDTH-1:0] mem [NUMWORDS];

  always_ff @(posedge clk) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end
endmodule

// File: rtl/smbus_mailbox_fifo_v2.sv
// Mailbox FIFO over a single-port RAM; pops appear 1 cycle later with rd_valid.
// No backpressure: full drops pushes (overflow), a push steals the port from a pop (collision).
module smbus_mailbox_fifo_v2
  import smbus_mailbox_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         DATA_DEPTH   = 1023,
  parameter int         AFULL_THRESH = DATA_DEPTH - 1,
  parameter peek_mode_e PEEK_MODE    = PEEK_LAST
) (
  input  logic                    clk,
  input  logic                    resetn,
  smbus_mailbox_fifo_v2_if.slave  bus
);
  localparam int PW = $clog2(DATA_DEPTH);
  localparam int CW = $clog2(DATA_DEPTH + 1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_prev, ram_addr;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, empty_prev_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d, col_q, col_d;
  logic                  empty, full, push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_q;

  assign empty   = (count_q == '0);
  assign full    = (32'(count_q) == DATA_DEPTH);
  assign wr_prev = PW'(ptr_wrap(32'(wr_ptr_q), DATA_DEPTH, 1'b1));

  always_comb begin
    push_ok  = bus.enqueue & ~full & ~bus.clear;
    pop_ok   = bus.dequeue & ~empty & ~push_ok & ~bus.clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A new set event wins over flag_clr; clear wins over everything below.
    ovf_d    = (bus.enqueue & full) | (ovf_q & ~bus.flag_clr);
    udf_d    = (bus.dequeue & empty & ~bus.enqueue) | (udf_q & ~bus.flag_clr);
    col_d    = (bus.dequeue & push_ok) | (col_q & ~bus.flag_clr);
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      col_d    = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = PW'(ptr_wrap(32'(wr_ptr_q), DATA_DEPTH, 1'b0));
        count_d  = count_q + CW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = PW'(ptr_wrap(32'(rd_ptr_q), DATA_DEPTH, 1'b0));
        count_d  = count_q - CW'(1);
      end
    end
  end

  always_comb begin
    ram_addr = (PEEK_MODE == PEEK_HEAD) ? rd_ptr_q : wr_prev;
    if (push_ok)     ram_addr = wr_ptr_q;
    else if (pop_ok) ram_addr = rd_ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      empty_prev_q <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      col_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_valid_q   <= pop_ok;
      empty_prev_q <= empty;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      col_q        <= col_d;
    end
  end

  sp_ram #(
    .NUMWORDS      (DATA_DEPTH),
    .ADDRESS_WIDTH (PW),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .address (ram_addr),
    .wren    (push_ok),
    .data    (bus.data_in),
    .q       (ram_q)
  );

  // q is meaningful when a pop or a peek of a non-empty FIFO was issued last cycle.
  assign bus.data_out    = (rd_valid_q | ~empty_prev_q) ? ram_q : '0;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (32'(count_q) >= AFULL_THRESH);
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.collision   = col_q;
endmodule

// File: tb/tb_smbus_mailbox_fifo_v2.sv
// Scoreboard bench: two 4-deep instances (last-word and head peek) share one stimulus stream.
module tb_smbus_mailbox_fifo_v2;
  import smbus_mailbox_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       enqueue, dequeue, clear, flag_clr;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [8:0] st0, st1;

  always #5 clk = ~clk;

  smbus_mailbox_fifo_v2_if #(.DATA_WIDTH(8), .DATA_DEPTH(4)) if0 ();
  smbus_mailbox_fifo_v2_if #(.DATA_WIDTH(8), .DATA_DEPTH(4)) if1 ();

  assign if0.data_in  = data_in;
  assign if0.enqueue  = enqueue;
  assign if0.dequeue  = dequeue;
  assign if0.clear    = clear;
  assign if0.flag_clr = flag_clr;
  assign if1.data_in  = data_in;
  assign if1.enqueue  = enqueue;
  assign if1.dequeue  = dequeue;
  assign if1.clear    = clear;
  assign if1.flag_clr = flag_clr;

  smbus_mailbox_fifo_v2 #(.DATA_WIDTH(8), .DATA_DEPTH(4), .AFULL_THRESH(3), .PEEK_MODE(PEEK_LAST))
    dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  smbus_mailbox_fifo_v2 #(.DATA_WIDTH(8), .DATA_DEPTH(4), .AFULL_THRESH(3), .PEEK_MODE(PEEK_HEAD))
    dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  assign st0 = {if0.count, if0.empty, if0.full, if0.almost_full, if0.overflow, if0.underflow, if0.collision};
  assign st1 = {if1.count, if1.empty, if1.full, if1.almost_full, if1.overflow, if1.underflow, if1.collision};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // status = {count, empty, full, almost_full, overflow, underflow, collision}
  task automatic chk_st(input string nm, input int cnt, input logic e, input logic f, input logic a,
                        input logic o, input logic u, input logic c);
    logic [8:0] req;
    req = {3'(cnt), e, f, a, o, u, c};
    check({nm, "/last"}, 32'(st0), 32'(req));
    check({nm, "/head"}, 32'(st1), 32'(req));
  endtask

  task automatic chk_out(input string nm, input logic rdv, input logic [7:0] d0, input logic [7:0] d1);
    check({nm, "/rdv_last"}, 32'(if0.rd_valid), 32'(rdv));
    check({nm, "/rdv_head"}, 32'(if1.rd_valid), 32'(rdv));
    check({nm, "/dout_last"}, 32'(if0.data_out), 32'(d0));
    check({nm, "/dout_head"}, 32'(if1.data_out), 32'(d1));
  endtask

  task automatic step(input logic enq, input logic deq, input logic [7:0] d,
                      input logic clr = 1'b0, input logic fclr = 1'b0);
    enqueue = enq; dequeue = deq; data_in = d; clear = clr; flag_clr = fclr;
    @(posedge clk); #1;
    enqueue = 1'b0; dequeue = 1'b0; clear = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b0, d);
  endtask

  task automatic pop(input logic [7:0] e);
    exp0.push_back(e);
    exp1.push_back(e);
    step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: every rd_valid beat must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn) begin
      if (if0.rd_valid) begin
        if (exp0.size() == 0) check("unexpected_pop_last", 32'(if0.data_out), 32'hFFFF_FFFF);
        else check("pop_last", 32'(if0.data_out), 32'(exp0.pop_front()));
      end
      if (if1.rd_valid) begin
        if (exp1.size() == 0) check("unexpected_pop_head", 32'(if1.data_out), 32'hFFFF_FFFF);
        else check("pop_head", 32'(if1.data_out), 32'(exp1.pop_front()));
      end
    end
  end

  initial begin
    resetn = 1'b0; data_in = '0; enqueue = 1'b0; dequeue = 1'b0; clear = 1'b0; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("reset", 0, 1, 0, 0, 0, 0, 0);
    chk_out("reset", 1'b0, 8'h00, 8'h00);
    resetn = 1'b1;

    // Fill then overflow
    push(8'h11); chk_st("fill1", 1, 0, 0, 0, 0, 0, 0);
    push(8'h22); chk_st("fill2", 2, 0, 0, 0, 0, 0, 0);
    push(8'h33); chk_st("fill3", 3, 0, 0, 1, 0, 0, 0);
    push(8'h44); chk_st("fill4", 4, 0, 1, 1, 0, 0, 0);
    push(8'h55); chk_st("ovf", 4, 0, 1, 1, 1, 0, 0);
    pop(8'h11);  chk_st("drain1", 3, 0, 0, 1, 1, 0, 0);
    pop(8'h22);  chk_st("drain2", 2, 0, 0, 0, 1, 0, 0);
    pop(8'h33);
    pop(8'h44);  chk_st("drain4", 0, 1, 0, 0, 1, 0, 0);
    idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_st("ovf_clr", 0, 1, 0, 0, 0, 0, 0);

    // Wrap-around, count never above 2
    push(8'hA0);
    push(8'hA1);
    for (int i = 2; i < 10; i++) begin
      pop(8'(8'hA0 + i - 2));
      push(8'(8'hA0 + i));
    end
    pop(8'hA8);
    pop(8'hA9);
    idle();
    chk_st("wrap_end", 0, 1, 0, 0, 0, 0, 0);

    // Collision: push wins, pop dropped
    push(8'h11);
    step(1'b1, 1'b1, 8'h22);
    chk_st("collide", 2, 0, 0, 0, 0, 0, 1);
    check("collide/rdv_last", 32'(if0.rd_valid), 32'd0);
    check("collide/rdv_head", 32'(if1.rd_valid), 32'd0);
    pop(8'h11);
    pop(8'h22);
    idle();
    chk_st("collide_sticky", 0, 1, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Peek modes
    push(8'h10);
    push(8'h20);
    idle();
    chk_out("peek", 1'b0, 8'h20, 8'h10);
    pop(8'h10);
    pop(8'h20);
    idle();
    chk_out("peek_empty", 1'b0, 8'h00, 8'h00);
    chk_st("peek_empty", 0, 1, 0, 0, 0, 0, 0);

    // Underflow and flag clear
    step(1'b0, 1'b1, 8'h00);
    chk_st("udf", 0, 1, 0, 0, 0, 1, 0);
    chk_out("udf", 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_st("udf_clr", 0, 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk_st("udf_set_wins", 0, 1, 0, 0, 0, 1, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Clear beats a simultaneous enqueue
    push(8'h01);
    push(8'h02);
    step(1'b1, 1'b1, 8'h03);
    chk_st("pre_clear", 3, 0, 0, 1, 0, 0, 1);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    chk_st("clear", 0, 1, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 8'h00);
    chk_st("clear_pop", 0, 1, 0, 0, 0, 1, 0);
    chk_out("clear_pop", 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a burst
    push(8'h31);
    step(1'b1, 1'b1, 8'h32);
    pop(8'h31);
    #5;
    enqueue = 1'b1; data_in = 8'h33;
    resetn = 1'b0;
    #1;
    chk_st("reset_mid", 0, 1, 0, 0, 0, 0, 0);
    chk_out("reset_mid", 1'b0, 8'h00, 8'h00);
    enqueue = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle();
    idle();

    check("sb_left_last", 32'(exp0.size()), 32'd0);
    check("sb_left_head", 32'(exp1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
